input_ddr_deser: RTL and testbench

//  Multi-channel input DDR deserializer: per channel, takes the 2-bit pair from an I_DDR
//  (two samples per CLK) and assembles RATIO-bit words with per-channel bitslip alignment.

---
 rtl/input_ddr_deser_pkg.sv | 22 ++
 rtl/input_ddr_deser_lane.sv | 53 +++++
 rtl/input_ddr_deser.sv | 66 ++++++
 tb/tb_input_ddr_deser.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/input_ddr_deser_pkg.sv
// Shared sizing helpers and legal parameter ranges for the input DDR deserializer.
package input_ddr_deser_pkg;

   localparam int CHANNELS_MIN = 1;
   localparam int CHANNELS_MAX = 32;
   localparam int RATIO_MIN    = 2;
   localparam int RATIO_MAX    = 16;

   function automatic int cnt_w_f(input int ratio);
      return ($clog2(ratio / 2) < 1) ? 1 : $clog2(ratio / 2);
   endfunction

   function automatic int slip_w_f(input int ratio);
      return ($clog2(ratio) < 1) ? 1 : $clog2(ratio);
   endfunction

   function automatic bit params_ok_f(input int channels, input int ratio);
      return (channels >= CHANNELS_MIN) && (channels <= CHANNELS_MAX) &&
             (ratio >= RATIO_MIN) && (ratio <= RATIO_MAX) && ((ratio % 2) == 0);
   endfunction

endpackage

// File: rtl/input_ddr_deser_lane.sv
// One deserializer lane: 2*RATIO-bit sample history, bitslip index and word register.
module input_ddr_deser_lane
   import input_ddr_deser_pkg::*;
#(
   parameter int RATIO = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic [1:0]       pair_i,
   input  logic             bitslip_i,
   input  logic             s_i,
   output logic [RATIO-1:0] word_o
);

   localparam int SLIP_W = slip_w_f(RATIO);
   localparam logic [SLIP_W-1:0] K_MAX = SLIP_W'(RATIO - 1);

   logic [2*RATIO-1:0] h_q, h_d;
   logic [SLIP_W-1:0]  k_q, k_d;
   logic [RATIO-1:0]   q_q, q_d;

   always_comb begin
      h_d = h_q;
      k_d = k_q;
      q_d = q_q;
      if (en_i) begin
         h_d = {h_q[2*RATIO-3:0], pair_i};
      end
      if (bitslip_i) begin
         k_d = (k_q == K_MAX) ? '0 : k_q + SLIP_W'(1);
      end
      // A larger index picks a window further back in time, i.e. older bits.
      if (s_i) begin
         q_d = h_q[k_q +: RATIO];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         h_q <= '0;
         k_q <= '0;
         q_q <= '0;
      end else begin
         h_q <= h_d;
         k_q <= k_d;
         q_q <= q_d;
      end
   end

   assign word_o = q_q;

endmodule

// File: rtl/input_ddr_deser.sv
// Multi-lane input DDR deserializer: shared pair counter and word strobe, one lane per channel.
module input_ddr_deser
   import input_ddr_deser_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int RATIO    = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      en_i,
   input  logic [2*CHANNELS-1:0]     din_pair_i,
   input  logic [CHANNELS-1:0]       bitslip_i,
   output logic [CHANNELS*RATIO-1:0] q_o,
   output logic                      q_valid_o
);

   localparam int CNT_W = cnt_w_f(RATIO);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO / 2 - 1);

   if (!params_ok_f(CHANNELS, RATIO)) begin : g_param_err
      $error("input_ddr_deser: CHANNELS must be 1..32 and RATIO even in 2..16");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s_q, s_d;
   logic             valid_q, valid_d;

   always_comb begin
      cnt_d   = cnt_q;
      s_d     = 1'b0;
      valid_d = s_q;
      if (en_i) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         s_d   = (cnt_q == CNT_LAST);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q   <= '0;
         s_q     <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         valid_q <= valid_d;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      input_ddr_deser_lane #(
         .RATIO (RATIO)
      ) u_lane (
         .clk_i     (clk_i),
         .rst_n_i   (rst_n_i),
         .en_i      (en_i),
         .pair_i    (din_pair_i[2*c+1:2*c]),
         .bitslip_i (bitslip_i[c]),
         .s_i       (s_q),
         .word_o    (q_o[c*RATIO +: RATIO])
      );
   end

   assign q_valid_o = valid_q;

endmodule

// File: tb/tb_input_ddr_deser.sv
// Bench for input_ddr_deser: directed word/stream/slip/gap cases plus random traffic vs a bit-stream model.
module tb_input_ddr_deser;

   localparam int CH   = 2;
   localparam int R    = 4;
   localparam int HALF = R / 2;
   localparam int MAXB = 4096;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic [2*CH-1:0]   din = '0;
   logic [CH-1:0]     slip = '0;
   logic [CH*R-1:0]   q;
   logic              qv;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: every accepted sample per lane, oldest first; the word is a window counted back from the newest.
   bit            strm_m [CH][MAXB];
   int            n_m;
   int            pairs_m;
   int            k_m [CH];
   bit            s_m;
   bit            exp_v_m;
   logic [CH*R-1:0] exp_q_m;

   always #5 clk = ~clk;

   input_ddr_deser #(
      .CHANNELS (CH),
      .RATIO    (R)
   ) u_dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .en_i       (en),
      .din_pair_i (din),
      .bitslip_i  (slip),
      .q_o        (q),
      .q_valid_o  (qv)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic model_reset();
      n_m     = 0;
      pairs_m = 0;
      s_m     = 1'b0;
      exp_v_m = 1'b0;
      exp_q_m = '0;
      for (int c = 0; c < CH; c++) k_m[c] = 0;
   endtask

   function automatic logic [R-1:0] model_word(input int c);
      logic [R-1:0] w;
      int idx;
      for (int j = 0; j < R; j++) begin
         idx  = n_m - 1 - (j + k_m[c]);
         w[j] = (idx >= 0) ? strm_m[c][idx] : 1'b0;
      end
      return w;
   endfunction

   task automatic model_edge();
      bit s_new;
      if (s_m) begin
         for (int c = 0; c < CH; c++) exp_q_m[c*R +: R] = model_word(c);
         exp_v_m = 1'b1;
      end else begin
         exp_v_m = 1'b0;
      end
      s_new = en && ((pairs_m % HALF) == HALF - 1);
      if (en) begin
         for (int c = 0; c < CH; c++) begin
            strm_m[c][n_m]     = din[2*c+1];
            strm_m[c][n_m + 1] = din[2*c];
         end
         n_m     += 2;
         pairs_m += 1;
      end
      for (int c = 0; c < CH; c++) if (slip[c]) k_m[c] = (k_m[c] + 1) % R;
      s_m = s_new;
   endtask

   task automatic step(input logic e, input logic [2*CH-1:0] d, input logic [CH-1:0] s);
      en   = e;
      din  = d;
      slip = s;
      @(posedge clk);
      model_edge();
      #1;
      chk("q_valid", {63'd0, qv}, {63'd0, exp_v_m});
      chk("q", {56'd0, q}, {56'd0, exp_q_m});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_async_q", {56'd0, q}, 64'd0);
      chk("rst_async_v", {63'd0, qv}, 64'd0);
      en   = 1'b1;
      din  = 4'b1111;
      slip = '0;
      @(posedge clk);
      #1;
      chk("rst_hold_q", {56'd0, q}, 64'd0);
      rst_n = 1'b1;
   endtask

   task automatic stream_chunk(input int words, input logic [CH-1:0] first_slip,
                               input logic [R-1:0] old_w, input logic [R-1:0] new_w);
      logic [1:0] l0, l1;
      for (int i = 0; i < 2 * words; i++) begin
         l0 = (i % 2 == 0) ? 2'b00 : 2'b01;
         l1 = (i % 2 == 0) ? 2'b10 : 2'b11;
         step(1'b1, {l1, l0}, (i == 0) ? first_slip : '0);
         if (qv) begin
            if (i == 0) chk("slip_same_edge_old", {60'd0, q[3:0]}, {60'd0, old_w});
            else        chk("stream_lane0", {60'd0, q[3:0]}, {60'd0, new_w});
            chk("stream_lane1", {60'd0, q[7:4]}, 64'hB);
         end
      end
   endtask

   initial begin
      model_reset();
      #1;
      chk("reset_q", {56'd0, q}, 64'd0);
      chk("reset_v", {63'd0, qv}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset mid-word discards the partial word
      step(1'b1, 4'b1101, '0);
      do_reset();
      step(1'b1, 4'b0010, '0);
      step(1'b1, 4'b0011, '0);
      step(1'b0, 4'b0000, '0);
      chk("basic_valid", {63'd0, qv}, 64'd1);
      chk("basic_word", {60'd0, q[3:0]}, 64'hB);
      step(1'b0, 4'b0000, '0);
      chk("basic_one_cycle", {63'd0, qv}, 64'd0);
      chk("basic_hold", {60'd0, q[3:0]}, 64'hB);

      stream_chunk(4, 2'b00, 4'b0001, 4'b0001);
      stream_chunk(4, 2'b01, 4'b0001, 4'b1000);
      stream_chunk(2, 2'b01, 4'b1000, 4'b0100);
      stream_chunk(2, 2'b01, 4'b0100, 4'b0010);
      stream_chunk(4, 2'b01, 4'b0010, 4'b0001);

      step(1'b0, 4'b0000, '0);
      step(1'b1, 4'b0011, '0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'($urandom), '0);
         chk("gap_no_valid", {63'd0, qv}, 64'd0);
      end
      step(1'b1, 4'b0000, '0);
      step(1'b0, 4'b0000, '0);
      chk("gap_valid", {63'd0, qv}, 64'd1);
      chk("gap_word", {60'd0, q[3:0]}, 64'hC);

      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         step($urandom_range(0, 3) != 0, 4'($urandom),
              ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
